rr_arbiter_8: RTL

//  Round-robin arbiter that shares one resource among 8 requesters.

---
 rtl/rr_arbiter_8_if.sv | 20 ++
 rtl/rr_arbiter_8.sv | 117 +++++++++++
 2 files changed

// File: rtl/rr_arbiter_8_if.sv
// Requester-side bus of the 8-way round-robin arbiter.
// The master side drives req. The slave side (the arbiter) drives the grant outputs and the FSM state view.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       preempt;
  logic [1:0] fsm_state;

  modport master (
    output req,
    input  grant, grant_idx, grant_valid, preempt, fsm_state
  );

  modport slave (
    input  req,
    output grant, grant_idx, grant_valid, preempt, fsm_state
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant and an encoded index.
// A grant is held while its requester keeps req high. It can be preempted after MAX_HOLD cycles.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter_8_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // With MAX_HOLD == 0 the counter saturates at all-ones and never preempts.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_n;
  logic [2:0]        ptr, ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [7:0]        grant, grant_n;
  logic [2:0]        grant_idx, idx_n;
  logic              preempt, preempt_n;

  logic              pick_found;
  logic [2:0]        pick_idx;
  logic [2:0]        cand;

  // Rotating priority search: the first set bit at or after ptr, wrapping modulo 8.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    grant_n   = grant;
    idx_n     = grant_idx;
    preempt_n = 1'b0;
    case (state)
      IDLE, GAP: begin
        grant_n = '0;
        idx_n   = '0;
        hold_n  = '0;
        state_n = IDLE;
        if (pick_found) begin
          grant_n = 8'(1) << pick_idx;
          idx_n   = pick_idx;
          state_n = BUSY;
        end
      end
      BUSY: begin
        // Release takes priority over expiry, so a release never raises preempt.
        if (!bus.req[grant_idx]) begin
          grant_n = '0;
          idx_n   = '0;
          ptr_n   = grant_idx + 3'd1;
          state_n = GAP;
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) &&
                     (|(bus.req & ~grant))) begin
          grant_n   = '0;
          idx_n     = '0;
          preempt_n = 1'b1;
          ptr_n     = grant_idx + 3'd1;
          state_n   = GAP;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        idx_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      grant     <= grant_n;
      grant_idx <= idx_n;
      preempt   <= preempt_n;
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_idx   = grant_idx;
  assign bus.grant_valid = |grant;
  assign bus.preempt     = preempt;
  assign bus.fsm_state   = state;

endmodule
